rgb_pwm_sequencer: RTL and testbench

Parametrised successor to the blinky LED driver for the board's RGB LED. It generates W-bit PWM on three channels and sequences brightness in one of four modes: off, solid, blink and breathe. Step rate comes from an N-bit prescaler counted in PWM periods. It sits between board-level control inputs (switches or a host register) and the `led_blue`, `led_green` and `led_red` pads.

---
 rtl/rgb_pwm_sequencer.sv | 152 +++++++++++++++
 tb/tb_rgb_pwm_sequencer.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/rgb_pwm_sequencer.sv
// rtl/rgb_pwm_sequencer.sv - three-channel PWM with off/solid/blink/breathe brightness sequencing
// Optional feature macro: RGB_PWM_GAMMA_EN (squared-duty gamma curve in BREATHE mode).
module rgb_pwm_sequencer #(
    parameter int W = 8,
    parameter int N = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic [1:0] mode,
    input  logic [2:0] color,
    output logic       led_blue,
    output logic       led_green,
    output logic       led_red,
    output logic       period_strobe
);

    typedef enum logic [1:0] {
        MODE_OFF     = 2'b00,
        MODE_SOLID   = 2'b01,
        MODE_BLINK   = 2'b10,
        MODE_BREATHE = 2'b11
    } mode_t;

    localparam logic [W-1:0] L_MAX     = {W{1'b1}};
    localparam logic [N-1:0] L_PRE_MAX = {N{1'b1}};

    logic [W-1:0] r_pwm_cnt;
    logic [N-1:0] r_pre_cnt;
    logic [W-1:0] r_level;
    logic         r_dir;       // 0 = counting up, 1 = counting down
    mode_t        r_mode_q;
    logic [2:0]   r_color_q;

    logic         w_boundary;
    logic         w_mode_chg;
    logic         w_step;
    logic [W-1:0] w_level_nxt;
    logic         w_dir_nxt;
    logic [W-1:0] w_duty;
    logic         w_on;

    // Last clock of a PWM period; shadow registers and the prescaler move only here.
    assign w_boundary = en && (r_pwm_cnt == L_MAX);
    assign w_mode_chg = w_boundary && (mode_t'(mode) != r_mode_q);
    // A step coinciding with a mode change is dropped so the new mode starts clean.
    assign w_step     = w_boundary && (r_pre_cnt == L_PRE_MAX) && !w_mode_chg;

`ifdef RGB_PWM_GAMMA_EN
    logic [W-1:0] w_gamma;
    assign w_gamma = W'(({{W{1'b0}}, r_level} * {{W{1'b0}}, r_level}) >> W);
    assign w_duty  = (r_mode_q == MODE_BREATHE) ? w_gamma : r_level;
`else
    assign w_duty  = r_level;
`endif

    assign w_on = (r_pwm_cnt < w_duty);

    // Level machine next state: OFF/SOLID hold their fixed level, BLINK/BREATHE move on steps.
    always_comb begin
        w_level_nxt = r_level;
        w_dir_nxt   = r_dir;
        if (w_mode_chg) begin
            w_level_nxt = '0;
            w_dir_nxt   = 1'b0;
        end else begin
            case (r_mode_q)
                MODE_OFF: begin
                    w_level_nxt = '0;
                end
                MODE_SOLID: begin
                    w_level_nxt = L_MAX;
                end
                MODE_BLINK: begin
                    if (w_step) begin
                        w_level_nxt = (r_level == '0) ? L_MAX : '0;
                    end
                end
                MODE_BREATHE: begin
                    if (w_step) begin
                        if (!r_dir) begin
                            if (r_level == L_MAX) begin
                                w_dir_nxt   = 1'b1;
                                w_level_nxt = L_MAX - 1'b1;
                            end else begin
                                w_level_nxt = r_level + 1'b1;
                            end
                        end else begin
                            if (r_level == '0) begin
                                w_dir_nxt   = 1'b0;
                                w_level_nxt = {{(W-1){1'b0}}, 1'b1};
                            end else begin
                                w_level_nxt = r_level - 1'b1;
                            end
                        end
                    end
                end
                default: begin
                    w_level_nxt = '0;
                end
            endcase
        end
    end

    // PWM and prescaler counters plus boundary-sampled shadow registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pwm_cnt <= '0;
            r_pre_cnt <= '0;
            r_mode_q  <= MODE_OFF;
            r_color_q <= 3'b000;
        end else if (en) begin
            r_pwm_cnt <= r_pwm_cnt + 1'b1;
            if (w_boundary) begin
                r_mode_q  <= mode_t'(mode);
                r_color_q <= color;
                if (w_mode_chg) begin
                    r_pre_cnt <= '0;
                end else begin
                    r_pre_cnt <= r_pre_cnt + 1'b1;
                end
            end
        end
    end

    // Level and direction state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_level <= '0;
            r_dir   <= 1'b0;
        end else begin
            r_level <= w_level_nxt;
            r_dir   <= w_dir_nxt;
        end
    end

    // Registered pad drivers and the end-of-period strobe.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            led_blue      <= 1'b0;
            led_green     <= 1'b0;
            led_red       <= 1'b0;
            period_strobe <= 1'b0;
        end else begin
            led_blue      <= en & r_color_q[0] & w_on;
            led_green     <= en & r_color_q[1] & w_on;
            led_red       <= en & r_color_q[2] & w_on;
            period_strobe <= w_boundary;
        end
    end

endmodule

// File: tb/tb_rgb_pwm_sequencer.sv
// tb/tb_rgb_pwm_sequencer.sv - self-checking bench for rgb_pwm_sequencer at W=4, N=2
module tb_rgb_pwm_sequencer;

    localparam int W    = 4;
    localparam int N    = 2;
    localparam int MAXV = 15;

    logic       clk = 1'b0;
    logic       reset;
    logic       en;
    logic [1:0] mode;
    logic [2:0] color;
    logic       led_blue;
    logic       led_green;
    logic       led_red;
    logic       period_strobe;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model state: position in period, boundaries and steps since mode entry.
    int         m_pwm;
    int         m_p;
    int         m_k;
    logic [1:0] m_mq;
    logic [2:0] m_cq;
    bit         m_fresh;

    rgb_pwm_sequencer #(.W(W), .N(N)) dut (
        .clk           (clk),
        .reset         (reset),
        .en            (en),
        .mode          (mode),
        .color         (color),
        .led_blue      (led_blue),
        .led_green     (led_green),
        .led_red       (led_red),
        .period_strobe (period_strobe)
    );

    always #5 clk = ~clk;

    function automatic int model_level();
        int r;
        case (m_mq)
            2'd1:    return m_fresh ? 0 : MAXV;
            2'd2:    return (m_k % 2 == 1) ? MAXV : 0;
            2'd3: begin
                r = m_k % (2 * MAXV);
                return (r <= MAXV) ? r : (2 * MAXV - r);
            end
            default: return 0;
        endcase
    endfunction

    function automatic int model_duty();
        int l;
        l = model_level();
`ifdef RGB_PWM_GAMMA_EN
        if (m_mq == 2'd3) return (l * l) / (MAXV + 1);
`endif
        return l;
    endfunction

    task automatic model_reset();
        m_pwm   = 0;
        m_p     = 0;
        m_k     = 0;
        m_mq    = 2'd0;
        m_cq    = 3'd0;
        m_fresh = 1'b0;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One clock: predict registered outputs, advance the model, then compare after the edge.
    task automatic clk_step(input string tag);
        logic [3:0] exp;
        int  d;
        bit  bnd;
        bit  on;
        d   = model_duty();
        bnd = (en === 1'b1) && (m_pwm == MAXV);
        on  = (en === 1'b1) && (m_pwm < d);
        exp = {bnd, on & m_cq[2], on & m_cq[1], on & m_cq[0]};
        m_fresh = 1'b0;
        if (en === 1'b1) begin
            if (bnd) begin
                if (mode != m_mq) begin
                    m_mq    = mode;
                    m_p     = 0;
                    m_k     = 0;
                    m_fresh = 1'b1;
                end else begin
                    m_p++;
                    if (m_p % (1 << N) == 0) m_k++;
                end
                m_cq = color;
            end
            m_pwm = (m_pwm + 1) % (MAXV + 1);
        end
        @(posedge clk);
        #1;
        check(tag, {4'b0, period_strobe, led_red, led_green, led_blue}, {4'b0, exp});
    endtask

    task automatic run(input int n, input string tag);
        for (int i = 0; i < n; i++) clk_step(tag);
    endtask

    task automatic seek_pwm(input int target, input string tag);
        int guard;
        guard = 0;
        while (m_pwm != target && guard < 40) begin
            clk_step(tag);
            guard++;
        end
        check({tag, "_seek"}, 8'(m_pwm), 8'(target));
    endtask

    initial begin
        reset = 1'b1;
        en    = 1'b1;
        mode  = 2'b01;
        color = 3'b101;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs", {4'b0, period_strobe, led_red, led_green, led_blue}, 8'h00);
        check("reset_pwm_cnt", 8'(dut.r_pwm_cnt), 8'h00);
        check("reset_pre_cnt", 8'(dut.r_pre_cnt), 8'h00);
        check("reset_level", {3'b0, dut.r_dir, dut.r_level}, 8'h00);
        check("reset_shadow", {3'b0, dut.r_mode_q, dut.r_color_q}, 8'h00);

        reset = 1'b0;
        run(40, "solid_start");
        run(64, "solid101");

        seek_pwm(9, "midreset");
        #2;
        reset = 1'b1;
        #1;
        check("async_reset_drop", {4'b0, period_strobe, led_red, led_green, led_blue}, 8'h00);
        model_reset();
        @(posedge clk);
        #1;
        check("reset_held", {4'b0, period_strobe, led_red, led_green, led_blue}, 8'h00);
        reset = 1'b0;
        run(60, "solid_after_reset");

        mode  = 2'b10;
        color = 3'b010;
        run(400, "blink010");

        mode  = 2'b11;
        color = 3'b111;
        run(2000, "breathe111");

        mode  = 2'b01;
        color = 3'b111;
        run(100, "solid_settle");
        seek_pwm(5, "switch");
        mode = 2'b00;
        run(13, "solid_to_off");
        check("switch_level", 8'(dut.r_level), 8'(model_level()));
        mode = 2'b01;
        run(80, "off_to_solid");

        seek_pwm(7, "enable");
        en = 1'b0;
        run(10, "en_hold");
        check("en_hold_pwm", 8'(dut.r_pwm_cnt), 8'd7);
        en = 1'b1;
        run(40, "en_resume");

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 99) < 2) mode = 2'($urandom);
            if ($urandom_range(0, 99) < 2) color = 3'($urandom);
            if (en === 1'b1) begin
                if ($urandom_range(0, 99) < 2) en = 1'b0;
            end else if ($urandom_range(0, 99) < 25) begin
                en = 1'b1;
            end
            clk_step("random");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
